// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one tinyalu-style ALU between NUM_REQ requesters.
// One operation in flight at a time; the result or an error returns to the granted requester only.
module alu_req_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned OP_WIDTH = 10,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_in1,
    input  logic [32*NUM_REQ-1:0]   req_in2,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [31:0]             rsp_result,
    output logic                    rsp_err,
    output logic                    alu_valid,
    input  logic                    alu_ready,
    output logic [OP_WIDTH-1:0]     alu_op,
    output logic [31:0]             alu_in1,
    output logic [31:0]             alu_in2,
    input  logic [31:0]             alu_result,
    input  logic                    alu_done,
    output logic                    busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 alu_valid_q, alu_valid_d;
    logic [OP_WIDTH-1:0]  alu_op_q, alu_op_d;
    logic [31:0]          alu_in1_q, alu_in1_d;
    logic [31:0]          alu_in2_q, alu_in2_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_result_q, rsp_result_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 busy_q, busy_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    int unsigned          scan_idx;
    logic [3:0]           win_op;
    logic [31:0]          win_in1;
    logic [31:0]          win_in2;

    // First requesting index at or above the rr pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = (32'(rr_q) + i) % NUM_REQ;
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(scan_idx);
            end
        end
    end

    assign win_op  = req_op[4*win_idx +: 4];
    assign win_in1 = req_in1[32*win_idx +: 32];
    assign win_in2 = req_in2[32*win_idx +: 32];

    // Accept is only offered from IDLE and is forced low while reset is held.
    assign req_ready = (rst_n && state_q == IDLE && win_found)
                       ? (NUM_REQ'(1) << win_idx) : '0;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        alu_valid_d  = alu_valid_q;
        alu_op_d     = alu_op_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    busy_d  = 1'b1;
                    if (32'(win_op) < OP_WIDTH) begin
                        state_d     = ISSUE;
                        alu_valid_d = 1'b1;
                        alu_op_d    = OP_WIDTH'(1) << win_op;
                        alu_in1_d   = win_in1;
                        alu_in2_d   = win_in2;
                    end else begin
                        state_d      = RESP;
                        rsp_valid_d  = NUM_REQ'(1) << win_idx;
                        rsp_result_d = '0;
                        rsp_err_d    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (alu_ready) begin
                    state_d     = WAIT;
                    cnt_d       = '0;
                    alu_valid_d = 1'b0;
                    alu_op_d    = '0;
                    alu_in1_d   = '0;
                    alu_in2_d   = '0;
                end
            end
            WAIT: begin
                // A done pulse in the final counted cycle still delivers the result.
                if (alu_done) begin
                    state_d      = RESP;
                    rsp_valid_d  = NUM_REQ'(1) << grant_q;
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = RESP;
                    rsp_valid_d  = NUM_REQ'(1) << grant_q;
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    state_d      = IDLE;
                    rsp_valid_d  = '0;
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b0;
                    busy_d       = 1'b0;
                    rr_d         = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            alu_valid_q  <= 1'b0;
            alu_op_q     <= '0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            alu_valid_q  <= alu_valid_d;
            alu_op_q     <= alu_op_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_valid  = alu_valid_q;
    assign alu_op     = alu_op_q;
    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;

endmodule
